// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS subset datapath (R-type, lw, sw, beq, addi, j).
// Moore outputs decoded from the current state. Exceptions: the FETCH PC/IR enables
// follow mem_ready, and the BEQ PC enable follows zero. Also keeps a wrapping count of
// retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_AEX    = 4'd10,
    S_AWB    = 4'd11,
    S_JMP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath selects and retire strobe.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 computed here; PC and IR load together when the fetch completes.
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_AEX;
          OP_J:         state_d = S_JMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_AEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_AWB;
      end
      S_AWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_src  = 2'd2;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  // Counter advances on the edge that leaves a retiring state; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;
  assign state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a table of per-cycle {inputs, expected state,
// expected outputs, expected count} plus hand sequences for the reset-in-MEMWR case.
// A second instance with a 2-bit counter runs in lockstep to show counter wrap.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic zero, mem_ready;

  logic mem_req, mem_we, iord, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg;
  logic reg_write, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic [3:0] state_o;

  logic s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_en, s_alu_src_a, s_reg_dst;
  logic s_mem_to_reg, s_reg_write, s_illegal_op;
  logic [1:0] s_pc_src, s_alu_src_b, s_alu_op;
  logic [1:0] s_instr_count;
  logic [3:0] s_state_o;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .instr_count(instr_count), .state_o(state_o)
  );

  mips_multicycle_ctrl #(.CNT_W(2), .STATE_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord), .ir_write(s_ir_write),
    .pc_en(s_pc_en), .pc_src(s_pc_src), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .alu_op(s_alu_op), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg),
    .reg_write(s_reg_write), .illegal_op(s_illegal_op), .instr_count(s_instr_count),
    .state_o(s_state_o)
  );

  // {mem_req, mem_we, iord, ir_write, pc_en, pc_src[1:0], alu_src_a, alu_src_b[1:0],
  //  alu_op[1:0], reg_dst, mem_to_reg, reg_write, illegal_op}
  logic [15:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

  localparam logic [3:0] RST = 0, FET = 1, DEC = 2, MAD = 3, MRD = 4, MWB = 5, MWR = 6,
                         REX = 7, RWB = 8, BEQ = 9, AEX = 10, AWB = 11, JMP = 12;

  localparam logic [15:0] O_RST = 16'h0000, O_FW = 16'h8040, O_FR = 16'h9840,
                          O_DEC = 16'h00C0, O_ILL = 16'h00C1, O_MAD = 16'h0180,
                          O_MRD = 16'hA000, O_MWB = 16'h0006, O_MWR = 16'hE000,
                          O_REX = 16'h0120, O_RWB = 16'h000A, O_BQ0 = 16'h0310,
                          O_BQ1 = 16'h0B10, O_AEX = 16'h0180, O_AWB = 16'h0002,
                          O_JMP = 16'h0C00;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BQ = 6'b000100, AD = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] out;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] out, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.out = out; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type
    add(R,  0, 1, RST, O_RST, 0);
    add(R,  0, 1, FET, O_FR,  0);
    add(R,  0, 1, DEC, O_DEC, 0);
    add(R,  0, 1, REX, O_REX, 0);
    add(R,  0, 1, RWB, O_RWB, 0);
    // lw with 3 wait cycles in MEMRD
    add(LW, 0, 1, FET, O_FR,  1);
    add(LW, 0, 1, DEC, O_DEC, 1);
    add(LW, 0, 1, MAD, O_MAD, 1);
    add(LW, 0, 0, MRD, O_MRD, 1);
    add(LW, 0, 0, MRD, O_MRD, 1);
    add(LW, 0, 0, MRD, O_MRD, 1);
    add(LW, 0, 1, MRD, O_MRD, 1);
    add(LW, 0, 1, MWB, O_MWB, 1);
    // sw with one fetch wait
    add(SW, 0, 0, FET, O_FW,  2);
    add(SW, 0, 1, FET, O_FR,  2);
    add(SW, 0, 1, DEC, O_DEC, 2);
    add(SW, 0, 0, MAD, O_MAD, 2);
    add(SW, 0, 1, MWR, O_MWR, 2);
    // beq not taken then taken
    add(BQ, 0, 1, FET, O_FR,  3);
    add(BQ, 0, 1, DEC, O_DEC, 3);
    add(BQ, 0, 1, BEQ, O_BQ0, 3);
    add(BQ, 1, 1, FET, O_FR,  4);
    add(BQ, 1, 1, DEC, O_DEC, 4);
    add(BQ, 1, 1, BEQ, O_BQ1, 4);
    // addi
    add(AD, 0, 1, FET, O_FR,  5);
    add(AD, 0, 1, DEC, O_DEC, 5);
    add(AD, 0, 1, AEX, O_AEX, 5);
    add(AD, 0, 1, AWB, O_AWB, 5);
    // illegal opcode, then j
    add(BAD,0, 1, FET, O_FR,  6);
    add(BAD,0, 1, DEC, O_ILL, 6);
    add(J,  0, 1, FET, O_FR,  6);
    add(J,  0, 1, DEC, O_DEC, 6);
    add(J,  0, 1, JMP, O_JMP, 6);
    // second j wraps the 2-bit counter 3 -> 0
    add(J,  0, 1, FET, O_FR,  7);
    add(J,  0, 1, DEC, O_DEC, 7);
    add(J,  0, 1, JMP, O_JMP, 7);
    add(R,  0, 0, FET, O_FW,  8);

    rst_n = 1'b0; opcode = R; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset_state", 32'(state_o), 32'(RST));
    check("reset_outs", 32'(outs), 32'(O_RST));
    check("reset_cnt", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].rdy;
      #1;
      check($sformatf("v%0d_state", i), 32'(state_o), 32'(vq[i].st));
      check($sformatf("v%0d_outs", i), 32'(outs), 32'(vq[i].out));
      check($sformatf("v%0d_cnt", i), instr_count, vq[i].cnt);
      check($sformatf("v%0d_cnt2", i), 32'(s_instr_count), 32'(vq[i].cnt[1:0]));
      @(negedge clk);
    end

    // Reset dropped while a sw holds mem_req in MEMWR.
    opcode = SW; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("memwr_state", 32'(state_o), 32'(MWR));
    check("memwr_outs", 32'(outs), 32'(O_MWR));
    @(negedge clk);
    #1;
    check("memwr_hold", 32'(outs), 32'(O_MWR));
    check("memwr_cnt", instr_count, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_state", 32'(state_o), 32'(RST));
    check("rstmid_mem_req", 32'(mem_req), 0);
    check("rstmid_outs", 32'(outs), 32'(O_RST));
    check("rstmid_cnt", instr_count, 0);
    @(posedge clk);
    #1;
    check("rsthold_state", 32'(state_o), 32'(RST));
    check("rsthold_outs", 32'(outs), 32'(O_RST));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_state", 32'(state_o), 32'(FET));
    check("rel_outs", 32'(outs), 32'(O_FW));
    check("rel_cnt2", 32'(s_instr_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
